// File: rtl/fifo_reader.sv
// fifo_reader: drains a read-latency-1 FIFO into a
// valid/ready stream through a 2-entry skid buffer.
module fifo_reader #(
  parameter int DWIDTH = 8,
  parameter int CWIDTH = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              en,
  input  logic              empty,
  input  logic [DWIDTH-1:0] data_out,
  output logic              rd,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CWIDTH-1:0] beat_count,
  output logic              busy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                infl_q, infl_d;
  logic [DWIDTH-1:0]   head_q, head_d;
  logic [DWIDTH-1:0]   tail_q, tail_d;
  logic [CWIDTH-1:0]   beat_q, beat_d;

  logic [1:0]          occ;
  logic [2:0]          level;
  logic                valid_raw;
  logic                pop;
  logic                cap;

  // Occupancy, handshake and read-issue decision.
  always_comb begin
    occ = 2'd0;
    unique case (state_q)
      EMPTY:   occ = 2'd0;
      HALF:    occ = 2'd1;
      FULL:    occ = 2'd2;
      default: occ = 2'd0;
    endcase
    valid_raw = (state_q != EMPTY);
    pop       = valid_raw && m_ready && !rst;
    cap       = infl_q;
    // Words owned after this edge; a new read
    // only fits if at most one slot is claimed.
    level     = {1'b0, occ}
              + {2'b00, infl_q}
              - {2'b00, pop};
    rd        = en && !empty && !rst
              && (level <= 3'd1);
  end

  // Next-state logic for buffer, flag and counter.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    infl_d  = rd;
    beat_d  = beat_q;
    if (pop) begin
      beat_d = beat_q + CWIDTH'(1);
    end
    unique case ({cap, pop})
      2'b10: begin
        unique case (state_q)
          EMPTY: begin
            state_d = HALF;
            head_d  = data_out;
          end
          HALF: begin
            state_d = FULL;
            tail_d  = data_out;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      2'b01: begin
        unique case (state_q)
          HALF: begin
            state_d = EMPTY;
          end
          FULL: begin
            state_d = HALF;
            head_d  = tail_q;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      2'b11: begin
        unique case (state_q)
          HALF: begin
            head_d = data_out;
          end
          FULL: begin
            head_d = tail_q;
            tail_d = data_out;
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q <= EMPTY;
      infl_q  <= 1'b0;
      head_q  <= '0;
      tail_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      infl_q  <= infl_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      beat_q  <= beat_d;
    end
  end

  // Stream outputs, forced quiet while reset is held.
  always_comb begin
    m_valid    = valid_raw && !rst;
    m_data     = rst ? '0 : head_q;
    busy       = (valid_raw || infl_q) && !rst;
    beat_count = beat_q;
  end

endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: table vectors, directed corner
// sequences and a random stream against a queue model.
module tb_fifo_reader;

  logic        clock = 1'b0;
  logic        rst;
  logic        en;
  logic        empty;
  logic [7:0]  data_out;
  logic        rd;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] beat_count;
  logic        busy;

  fifo_reader #(.DWIDTH(8), .CWIDTH(16)) dut (
    .clock      (clock),
    .rst        (rst),
    .en         (en),
    .empty      (empty),
    .data_out   (data_out),
    .rd         (rd),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .beat_count (beat_count),
    .busy       (busy)
  );

  always #5 clock = ~clock;

  int          vectors = 0;
  int          errors  = 0;
  logic [7:0]  fifo[$];
  logic [7:0]  exp_q[$];
  logic [15:0] beats = 0;
  bit          rd_prev = 0;
  bit          rst_prev = 0;
  bit          stall_prev = 0;
  logic [7:0]  stall_data = 0;
  int          rd_cnt = 0;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        rd;
    logic        v;
    logic [7:0]  d;
    logic        busy;
    logic [15:0] beat;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] w);
    fifo.push_back(w);
    empty = 1'b0;
  endtask

  // Called at a negedge: check outputs against the
  // transaction model, then advance to posedge+1.
  task automatic tick();
    bit rd_s;
    int nv;
    rd_s = 1'b0;
    if (rst) begin
      chk("rst_rd", rd, 0);
      chk("rst_valid", m_valid, 0);
      chk("rst_data", m_data, 0);
      chk("rst_busy", busy, 0);
      if (rst_prev) chk("rst_beat", beat_count, 0);
      exp_q.delete();
      beats = 0;
      stall_prev = 0;
      rst_prev = 1;
    end else begin
      rst_prev = 0;
      chk("rd_while_empty", rd && empty, 0);
      chk("occ_le2", exp_q.size() <= 2, 1);
      chk("busy", busy, exp_q.size() != 0);
      nv = exp_q.size() - (rd_prev ? 1 : 0);
      chk("valid", m_valid, nv > 0);
      if (m_valid && exp_q.size() > 0)
        chk("order", m_data, exp_q[0]);
      if (stall_prev) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_data", m_data, stall_data);
      end
      chk("beat", beat_count, beats);
      if (m_valid && m_ready) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats++;
      end
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      rd_s = rd;
      if (rd) rd_cnt++;
    end
    @(posedge clock);
    #1;
    if (rd_s && fifo.size() > 0) begin
      data_out = fifo.pop_front();
      exp_q.push_back(data_out);
    end else begin
      data_out = 8'($urandom);
    end
    rd_prev = rd_s;
    empty = (fifo.size() == 0);
  endtask

  task automatic cyc();
    @(negedge clock);
    tick();
  endtask

  task automatic do_reset(input int n, input bit clr);
    rst = 1'b1;
    en = 1'b0;
    m_ready = 1'b0;
    if (clr) begin
      fifo.delete();
      empty = 1'b1;
    end
    repeat (n) cyc();
    rst = 1'b0;
    rd_cnt = 0;
  endtask

  initial begin
    logic [15:0] wexp[4];
    logic [7:0]  nxt;
    int g;
    rst = 1'b1;
    en = 1'b0;
    empty = 1'b1;
    data_out = 8'h00;
    m_ready = 1'b0;

    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 16'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
    tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h11, 1'b1, 16'd0};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1, 16'd1};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h33, 1'b1, 16'd2};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd3};

    // Preloaded three words, free-running consumer.
    do_reset(2, 1);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    for (int i = 0; i < 7; i++) begin
      en = tbl[i].en;
      m_ready = tbl[i].rdy;
      @(negedge clock);
      chk($sformatf("t%0d_rd", i), rd, tbl[i].rd);
      chk($sformatf("t%0d_valid", i), m_valid, tbl[i].v);
      if (tbl[i].v)
        chk($sformatf("t%0d_data", i), m_data, tbl[i].d);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("t%0d_beat", i), beat_count,
          tbl[i].beat);
      tick();
    end

    // Stalled consumer: only two reads go out.
    do_reset(1, 1);
    for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i));
    en = 1'b1;
    rd_cnt = 0;
    repeat (8) cyc();
    chk("stall_rd_pulses", rd_cnt, 2);
    @(negedge clock);
    chk("stall_valid", m_valid, 1);
    chk("stall_head", m_data, 8'hA0);
    tick();
    m_ready = 1'b1;
    g = 0;
    while (beats != 16'd10 && g < 40) begin
      cyc();
      g++;
    end
    chk("stall_drain_count", beat_count, 10);

    // Consumer toggling ready every cycle.
    do_reset(1, 1);
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    en = 1'b1;
    g = 0;
    while (beats != 16'd8 && g < 60) begin
      m_ready = (g % 2 == 0);
      cyc();
      g++;
    end
    chk("toggle_count", beat_count, 8);
    chk("toggle_busy", busy, 0);

    // Enable dropped right after the first read.
    do_reset(1, 1);
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    cyc();
    en = 1'b0;
    rd_cnt = 0;
    repeat (6) cyc();
    chk("en_off_rd", rd_cnt, 0);
    chk("en_off_beats", beat_count, 1);
    chk("en_off_left", fifo.size(), 3);
    en = 1'b1;
    g = 0;
    while (beats != 16'd4 && g < 30) begin
      cyc();
      g++;
    end
    chk("en_on_count", beat_count, 4);

    // Reset with a full buffer discards it.
    do_reset(1, 1);
    for (int i = 0; i < 10; i++) push(8'hE0 + 8'(i));
    en = 1'b1;
    m_ready = 1'b1;
    repeat (4) cyc();
    m_ready = 1'b0;
    repeat (4) cyc();
    chk("pre_rst_busy", busy, 1);
    nxt = fifo[0];
    rst = 1'b1;
    repeat (2) cyc();
    rst = 1'b0;
    m_ready = 1'b1;
    g = 0;
    @(negedge clock);
    while (!m_valid && g < 10) begin
      tick();
      @(negedge clock);
      g++;
    end
    chk("post_rst_head", m_data, nxt);
    tick();

    // Beat counter wrap.
    do_reset(1, 1);
    en = 1'b1;
    m_ready = 1'b1;
    g = 0;
    while (beats != 16'hFFFE && g < 70000) begin
      if (fifo.size() < 4) push(8'($urandom));
      cyc();
      g++;
    end
    if (g >= 70000) chk("wrap_timeout", beats, 16'hFFFE);
    wexp[0] = 16'hFFFE;
    wexp[1] = 16'hFFFF;
    wexp[2] = 16'h0000;
    wexp[3] = 16'h0001;
    for (int k = 0; k < 4; k++) begin
      if (fifo.size() < 4) push(8'($urandom));
      @(negedge clock);
      chk($sformatf("wrap%0d", k), beat_count, wexp[k]);
      tick();
    end

    // Random traffic with occasional resets.
    do_reset(1, 1);
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom % 5) != 0;
      m_ready = $urandom % 2;
      rst = ($urandom % 100) == 0;
      if ($urandom % 3 == 0) push(8'($urandom));
      cyc();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule
